// File: rtl/lsu_ctrl.sv
// Load/store initiator: aligns store data, builds byte enables, handshakes with data_mem.
// Define LSU_MISALIGN_EXC_EN to reject misaligned requests instead of force-aligning them.
module lsu_ctrl #(
  parameter int unsigned ADDR_W = 18
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lsu_vld,
  input  logic              i_lsu_wren,
  input  logic [2:0]        i_lsu_op,
  input  logic [31:0]       i_lsu_addr,
  input  logic [31:0]       i_lsu_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [31:0]       o_ld_data,
  output logic              o_misalign,
  output logic [ADDR_W-1:0] o_ADDR,
  output logic [31:0]       o_WDATA,
  output logic [3:0]        o_BMASK,
  output logic              o_WREN,
  output logic              o_VALID,
  input  logic [31:0]       i_RDATA,
  input  logic              i_READY
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       ld_data_q;
  logic [3:0]        bmask_q;
  logic [2:0]        op_q;
  logic              wren_q;
  logic              valid_q;
  logic              done_q;
  logic              misalign_q;

  logic [1:0]  req_off;
  logic [1:0]  req_size;
  logic [1:0]  eff_off;
  logic [3:0]  req_bmask;
  logic [31:0] req_wdata;
  logic        reject;
  logic [15:0] rdata_sh;
  logic [31:0] ld_ext;
  logic        unused_addr;

  assign req_off     = i_lsu_addr[1:0];
  assign req_size    = i_lsu_op[1:0];
  assign unused_addr = ^i_lsu_addr[31:ADDR_W];

  // eff_off is the size-aligned offset; equal to req_off for any aligned request.
  always_comb begin
    eff_off   = 2'b00;
    req_bmask = 4'hf;
    req_wdata = i_lsu_wdata;
    unique case (req_size)
      2'b00: begin
        eff_off   = req_off;
        req_bmask = 4'b0001 << req_off;
        req_wdata = {4{i_lsu_wdata[7:0]}};
      end
      2'b01: begin
        eff_off   = {req_off[1], 1'b0};
        req_bmask = 4'b0011 << {req_off[1], 1'b0};
        req_wdata = {2{i_lsu_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!i_lsu_wren) begin
      req_bmask = 4'hf;
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  assign reject = ((req_size == 2'b01) && req_off[0]) || (req_size[1] && (req_off != 2'b00));
`else
  assign reject = 1'b0;
`endif

  assign rdata_sh = 16'(i_RDATA >> {addr_q[1:0], 3'b000});

  always_comb begin
    ld_ext = i_RDATA;
    unique case (op_q[1:0])
      2'b00:   ld_ext = op_q[2] ? {24'h0, rdata_sh[7:0]} : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      2'b01:   ld_ext = op_q[2] ? {16'h0, rdata_sh} : {{16{rdata_sh[15]}}, rdata_sh};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      ld_data_q  <= '0;
      bmask_q    <= '0;
      op_q       <= '0;
      wren_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_lsu_vld) begin
            if (reject) begin
              misalign_q <= 1'b1;
            end else begin
              state_q <= StBusy;
              valid_q <= 1'b1;
              addr_q  <= {i_lsu_addr[ADDR_W-1:2], eff_off};
              wdata_q <= req_wdata;
              bmask_q <= req_bmask;
              op_q    <= i_lsu_op;
              wren_q  <= i_lsu_wren;
            end
          end
        end
        StBusy: begin
          if (i_READY) begin
            state_q   <= StDone;
            valid_q   <= 1'b0;
            done_q    <= 1'b1;
            ld_data_q <= ld_ext;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_stall    = ((state_q == StIdle) && i_lsu_vld && !reject) || (state_q == StBusy);
  assign o_done     = done_q;
  assign o_ld_data  = ld_data_q;
  assign o_misalign = misalign_q;
  assign o_ADDR     = addr_q;
  assign o_WDATA    = wdata_q;
  assign o_BMASK    = bmask_q;
  assign o_WREN     = wren_q;
  assign o_VALID    = valid_q;

endmodule
